// File: rtl/nco_sweep_gen.sv
// nco_sweep_gen: phase-increment sweep generator feeding the NCO core.
// Steps the increment from a start value to a stop value (ascending or
// descending) in fixed steps and holds each level for a programmable dwell.
// The sweep runs once or repeats until aborted.
//
// Optional feature: define NCO_SWEEP_CNT_EN to add the sweep_cnt output,
// a 16-bit count of completed sweeps since the last accepted start.

module nco_sweep_gen #(
    parameter int unsigned PINC_W  = 32,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PINC_W-1:0]  cfg_start_pinc,
    input  logic [PINC_W-1:0]  cfg_stop_pinc,
    input  logic [PINC_W-1:0]  cfg_step_pinc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    output logic               out_valid,
    output logic [PINC_W-1:0]  out_data,
    output logic               busy,
    output logic               done
`ifdef NCO_SWEEP_CNT_EN
    ,
    output logic [15:0]        sweep_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinal
    } state_e;

    state_e state_q, state_d;

    // Shadow copies of the configuration, captured on an accepted start
    logic [PINC_W-1:0]  start_q, start_d;
    logic [PINC_W-1:0]  stop_q, stop_d;
    logic [PINC_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_rld_q, dwell_rld_d;
    logic               cont_q, cont_d;
    logic               dir_up_q, dir_up_d;

    // Current level and its remaining dwell (counts down to zero)
    logic [PINC_W-1:0]  cur_q, cur_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    // Dwell reload value: a dwell of 0 behaves as 1, so reload with max(d,1)-1
    logic [DWELL_W-1:0] cfg_dwell_rld;
    logic               dwell_exp;

    // Next-level arithmetic carried one bit wider so the ends never wrap
    logic [PINC_W:0]    sum_w;
    logic [PINC_W:0]    diff_w;
    logic               reach_up;
    logic               reach_dn;
    logic               reach_stop;
    logic [PINC_W-1:0]  next_lvl;

    logic               start_ok;

    // Derive reload value, dwell expiry and the candidate next level
    always_comb begin
        cfg_dwell_rld = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
        dwell_exp     = (dwell_cnt_q == '0);
        start_ok      = start && !abort;

        sum_w    = {1'b0, cur_q} + {1'b0, step_q};
        diff_w   = {1'b0, cur_q} - {1'b0, step_q};
        reach_up = (sum_w >= {1'b0, stop_q});
        // A borrow means the level went below zero, which is past any stop
        reach_dn = diff_w[PINC_W] || (diff_w[PINC_W-1:0] <= stop_q);
        next_lvl = dir_up_q ? sum_w[PINC_W-1:0] : diff_w[PINC_W-1:0];
        // A zero step jumps straight to the stop level
        reach_stop = (step_q == '0) || (dir_up_q ? reach_up : reach_dn);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_rld_d = dwell_rld_q;
        cont_d      = cont_q;
        dir_up_d    = dir_up_q;
        cur_d       = cur_q;
        dwell_cnt_d = dwell_cnt_q;
        valid_d     = valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    start_d     = cfg_start_pinc;
                    stop_d      = cfg_stop_pinc;
                    step_d      = cfg_step_pinc;
                    dwell_rld_d = cfg_dwell_rld;
                    cont_d      = cfg_continuous;
                    dir_up_d    = (cfg_stop_pinc >= cfg_start_pinc);
                    cur_d       = cfg_start_pinc;
                    dwell_cnt_d = cfg_dwell_rld;
                    valid_d     = 1'b1;
                    state_d     = (cfg_start_pinc == cfg_stop_pinc) ? StFinal : StRun;
                end
            end

            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    valid_d     = 1'b0;
                    cur_d       = '0;
                    dwell_cnt_d = '0;
                end else if (dwell_exp) begin
                    dwell_cnt_d = dwell_rld_q;
                    if (reach_stop) begin
                        cur_d   = stop_q;
                        state_d = StFinal;
                    end else begin
                        cur_d   = next_lvl;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end

            StFinal: begin
                if (abort) begin
                    state_d     = StIdle;
                    valid_d     = 1'b0;
                    cur_d       = '0;
                    dwell_cnt_d = '0;
                end else if (dwell_exp) begin
                    if (cont_q) begin
                        // Restart from the shadowed start level without a done pulse
                        cur_d       = start_q;
                        dwell_cnt_d = dwell_rld_q;
                        state_d     = (start_q == stop_q) ? StFinal : StRun;
                    end else begin
                        // out_data keeps the stop level while idle
                        state_d = StIdle;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end

            default: begin
                state_d     = StIdle;
                valid_d     = 1'b0;
                cur_d       = '0;
                dwell_cnt_d = '0;
            end
        endcase
    end

    // State, shadow configuration and output registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_rld_q <= '0;
            cont_q      <= 1'b0;
            dir_up_q    <= 1'b0;
            cur_q       <= '0;
            dwell_cnt_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_rld_q <= dwell_rld_d;
            cont_q      <= cont_d;
            dir_up_q    <= dir_up_d;
            cur_q       <= cur_d;
            dwell_cnt_q <= dwell_cnt_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

`ifdef NCO_SWEEP_CNT_EN
    logic [15:0] sweep_cnt_q, sweep_cnt_d;
    logic        sweep_complete;

    // Count completed sweeps; cleared on accepted start, untouched by abort
    always_comb begin
        sweep_complete = (state_q == StFinal) && !abort && dwell_exp;
        sweep_cnt_d    = sweep_cnt_q;
        if ((state_q == StIdle) && start_ok) begin
            sweep_cnt_d = '0;
        end else if (sweep_complete) begin
            sweep_cnt_d = sweep_cnt_q + 16'd1;
        end
    end

    // Sweep counter register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sweep_cnt_q <= '0;
        end else begin
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign sweep_cnt = sweep_cnt_q;
`endif

    assign out_valid = valid_q;
    assign out_data  = cur_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule
